// File: rtl/fifo_ptr_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ptr_pkg
// Shared pointer helpers for the dual-clock FIFO pointer controllers.
//   PTR_W    : default pointer width (wrap bit included), depth = 2^(PTR_W-1)
//   MAX_W    : widest pointer the conversion helpers can handle
//   bin2gray : binary -> Gray conversion, restricted to the low 'width' bits
//   gray2bin : Gray -> binary conversion, restricted to the low 'width' bits
// -----------------------------------------------------------------------------
package fifo_ptr_pkg;

    localparam int PTR_W = 4;
    localparam int MAX_W = 32;

    // Mask selecting the low 'width' bits of a MAX_W-wide vector.
    function automatic logic [MAX_W-1:0] width_mask(input int width);
        logic [MAX_W-1:0] mask;
        if (width >= MAX_W) begin
            mask = '1;
        end else begin
            mask = (MAX_W'(1) << width) - MAX_W'(1);
        end
        return mask;
    endfunction

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] bin,
                                                  input int               width);
        logic [MAX_W-1:0] b;
        b = bin & width_mask(width);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] gray,
                                                  input int               width);
        logic [MAX_W-1:0] b;
        logic             acc;
        acc = 1'b0;
        b   = '0;
        for (int i = MAX_W - 1; i >= 0; i--) begin
            if (i < width) begin
                acc  = acc ^ gray[i];
                b[i] = acc;
            end else begin
                b[i] = 1'b0;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/binary_to_gray.sv
// -----------------------------------------------------------------------------
// binary_to_gray
// Purely combinational binary-to-Gray encoder.
//   bin  : WIDTH-bit binary input
//   gray : WIDTH-bit Gray-coded output
// -----------------------------------------------------------------------------
module binary_to_gray
    import fifo_ptr_pkg::*;
#(
    parameter int WIDTH = PTR_W
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = WIDTH'(bin2gray(MAX_W'(bin), WIDTH));

endmodule

// File: rtl/gray_to_binary.sv
// -----------------------------------------------------------------------------
// gray_to_binary
// Purely combinational Gray-to-binary decoder.
//   gray : WIDTH-bit Gray-coded input
//   bin  : WIDTH-bit binary output
// -----------------------------------------------------------------------------
module gray_to_binary
    import fifo_ptr_pkg::*;
#(
    parameter int WIDTH = PTR_W
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    assign bin = WIDTH'(gray2bin(MAX_W'(gray), WIDTH));

endmodule

// File: rtl/gray_ptr_rd_ctrl.sv
// -----------------------------------------------------------------------------
// gray_ptr_rd_ctrl
// Read-side pointer controller of the dual-clock FIFO. Brings the write-domain
// Gray pointer across into clk, keeps the read binary/Gray pointers and
// produces registered empty / almost-empty / fill-level / underflow status.
//   clk          : read-domain clock
//   rst          : asynchronous active-high reset
//   rd_en        : read request
//   wptr_gray    : write pointer (Gray), asynchronous to clk
//   rptr_gray    : registered read pointer (Gray) for the write domain
//   raddr        : memory read address, low n-1 bits of the binary read pointer
//   rd_ack       : read accepted this cycle (rd_en & ~empty)
//   empty        : registered empty flag
//   almost_empty : registered, fill level <= AE_THRESH
//   rd_count     : registered fill level 0..2^(n-1)
//   underflow    : one-cycle pulse after a read request while empty
// -----------------------------------------------------------------------------
module gray_ptr_rd_ctrl
    import fifo_ptr_pkg::*;
#(
    parameter int n           = PTR_W,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rd_en,
    input  logic [n-1:0] wptr_gray,
    output logic [n-1:0] rptr_gray,
    output logic [n-2:0] raddr,
    output logic         rd_ack,
    output logic         empty,
    output logic         almost_empty,
    output logic [n-1:0] rd_count,
    output logic         underflow
);

    localparam logic [n-1:0] AE_LIMIT = n'(AE_THRESH);

    logic [n-1:0] wsync_s;
    logic [n-1:0] wbin_sync_s;
    logic [n-1:0] rbin_r;
    logic [n-1:0] rbin_next_s;
    logic [n-1:0] rgray_next_s;
    logic [n-1:0] rd_count_next_s;
    logic         empty_next_s;
    logic         almost_empty_next_s;

    // Plain flop chain: nothing may sit between stages so each stage only
    // ever samples a single-bit-changing Gray value.
    for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
        logic [n-1:0] q_r;
        logic [n-1:0] d_s;
        if (g == 0) begin : g_first
            assign d_s = wptr_gray;
        end else begin : g_next
            assign d_s = g_sync[g-1].q_r;
        end
        // Synchronizer stage register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q_r <= '0;
            end else begin
                q_r <= d_s;
            end
        end
    end

    assign wsync_s = g_sync[SYNC_STAGES-1].q_r;

    gray_to_binary #(.WIDTH(n)) u_wptr_dec (
        .gray (wsync_s),
        .bin  (wbin_sync_s)
    );

    binary_to_gray #(.WIDTH(n)) u_rptr_enc (
        .bin  (rbin_next_s),
        .gray (rgray_next_s)
    );

    // Reads are gated by the registered empty, so status can only lag writes.
    assign rd_ack = rd_en & ~empty;
    assign raddr  = rbin_r[n-2:0];

    // Next-state status from the advanced read pointer and the synced write pointer.
    always_comb begin
        rbin_next_s         = rbin_r + {{(n-1){1'b0}}, rd_ack};
        rd_count_next_s     = wbin_sync_s - rbin_next_s;
        empty_next_s        = (rgray_next_s == wsync_s);
        almost_empty_next_s = (rd_count_next_s <= AE_LIMIT);
    end

    // Read pointer and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbin_r       <= '0;
            rptr_gray    <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_count     <= '0;
            underflow    <= 1'b0;
        end else begin
            rbin_r       <= rbin_next_s;
            rptr_gray    <= rgray_next_s;
            empty        <= empty_next_s;
            almost_empty <= almost_empty_next_s;
            rd_count     <= rd_count_next_s;
            underflow    <= rd_en & empty;
        end
    end

endmodule

// File: tb/tb_gray_ptr_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gray_ptr_rd_ctrl
// Self-checking bench for gray_ptr_rd_ctrl (n=4, SYNC_STAGES=2, AE_THRESH=1).
// The reference model tracks pointers as plain integers mod 16 and delays the
// write pointer by a queue of SYNC_STAGES captures.
// -----------------------------------------------------------------------------
module tb_gray_ptr_rd_ctrl;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int AE = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_en;
    logic [N-1:0] wptr_gray;
    logic [N-1:0] rptr_gray;
    logic [N-2:0] raddr;
    logic         rd_ack;
    logic         empty;
    logic         almost_empty;
    logic [N-1:0] rd_count;
    logic         underflow;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int m_w;
    int m_r;
    int m_cnt;
    bit m_empty;
    bit m_ae;
    bit m_uf;
    int q[$];

    gray_ptr_rd_ctrl #(.n(N), .SYNC_STAGES(S), .AE_THRESH(AE)) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_en        (rd_en),
        .wptr_gray    (wptr_gray),
        .rptr_gray    (rptr_gray),
        .raddr        (raddr),
        .rd_ack       (rd_ack),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_count     (rd_count),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] to_gray(input int v);
        logic [3:0] b;
        b = 4'(v % 16);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_r     = 0;
        m_cnt   = 0;
        m_empty = 1'b1;
        m_ae    = 1'b1;
        m_uf    = 1'b0;
        q.delete();
        for (int i = 0; i < S; i++) q.push_back(0);
    endtask

    task automatic check_outputs();
        chk("raddr",        8'(raddr),        8'(m_r % 8));
        chk("rptr_gray",    8'(rptr_gray),    8'(to_gray(m_r)));
        chk("empty",        8'(empty),        8'(m_empty));
        chk("almost_empty", 8'(almost_empty), 8'(m_ae));
        chk("rd_count",     8'(rd_count),     8'(m_cnt));
        chk("underflow",    8'(underflow),    8'(m_uf));
    endtask

    // One read-clock cycle: drive, check rd_ack, advance model across the edge, check.
    task automatic step(input bit rd);
        bit ack;
        int seen;
        rd_en     = rd;
        wptr_gray = to_gray(m_w);
        #1;
        ack = rd && !m_empty;
        chk("rd_ack", 8'(rd_ack), 8'(ack));
        @(posedge clk);
        seen = q.pop_front();
        q.push_back(m_w % 16);
        m_uf    = rd && m_empty;
        m_r     = (m_r + int'(ack)) % 16;
        m_cnt   = (seen - m_r + 16) % 16;
        m_empty = (m_cnt == 0);
        m_ae    = (m_cnt <= AE);
        #1;
        check_outputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int inc;
        int fill;
        rst       = 1'b1;
        rd_en     = 1'b0;
        m_w       = 0;
        wptr_gray = 4'b0000;
        model_reset();

        // Reset held with rd_en toggling
        for (int i = 0; i < 4; i++) begin
            rd_en     = i[0];
            wptr_gray = to_gray(i + 3);
            #1;
            chk("rst_rd_ack", 8'(rd_ack), 8'(0));
            @(posedge clk);
            #1;
            check_outputs();
        end
        rst = 1'b0;
        model_reset();

        // Single write: becomes visible two edges after capture
        m_w = 1;
        repeat (4) step(1'b0);

        // Full drain of 8 entries, then an underflow attempt
        m_w = 8;
        repeat (3) step(1'b0);
        repeat (8) step(1'b1);
        step(1'b1);
        step(1'b0);

        // Wrap-around: read pointer to 15, write pointer to 1 (binary 17 mod 16)
        m_w = 15;
        repeat (3) step(1'b0);
        repeat (7) step(1'b1);
        m_w = 1;
        repeat (3) step(1'b0);
        step(1'b1);
        step(1'b1);
        step(1'b0);

        // Randomized traffic, fill kept within 0..8
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                inc  = int'($urandom_range(1, 2));
                fill = (m_w - m_r + 16) % 16;
                if (fill + inc <= 8) m_w = (m_w + inc) % 16;
            end
            step(1'(($urandom_range(0, 3) != 0) ? 1 : 0));
        end

        // Reset mid-operation with 5 entries held
        m_w = (m_r + 5) % 16;
        repeat (4) step(1'b0);
        chk("pre_reset_count", 8'(rd_count), 8'(5));
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;
        m_w = 6;
        repeat (4) step(1'b0);
        chk("post_reset_count", 8'(rd_count), 8'(6));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
